// File: rtl/counter_mod12_monitor.sv
// Sequence monitor for a modulo-N counter: locks onto the 0..N-1 ramp,
// flags sequence breaks while locked and tallies errors and legal wraps.
module counter_mod12_monitor #(
    parameter int unsigned N      = 12,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  count_in,
    output logic              locked,
    output logic              err_pulse,
    output logic              wrap_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [1:0]        state
);

    localparam int unsigned CMP_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
    localparam logic [CMP_W-1:0] LIMIT = CMP_W'(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [1:0]         good_q, good_d;
    logic               locked_d, err_pulse_d, wrap_pulse_d;
    logic [ERR_W-1:0]   err_count_d;
    logic [WRAP_W-1:0]  wrap_count_d;

    logic [WIDTH-1:0]   exp_c;
    logic               in_range_c;
    logic               match_c;

    // Widened compare so that N == 2**WIDTH still works.
    assign in_range_c = ({1'b0, count_in} < LIMIT);
    assign exp_c      = (prev_q == LAST) ? '0 : prev_q + WIDTH'(1);
    assign match_c    = in_range_c && (count_in == exp_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            good_q     <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            locked     <= locked_d;
            err_pulse  <= err_pulse_d;
            wrap_pulse <= wrap_pulse_d;
            err_count  <= err_count_d;
            wrap_count <= wrap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        err_count_d  = err_count;
        wrap_count_d = wrap_count;

        if (!en) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            prev_d = count_in;
            case (state_q)
                IDLE: begin
                    if (in_range_c) begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                end
                SYNC, LOST: begin
                    // Two consecutive matches after the capture re-establish lock.
                    if (match_c) begin
                        if (good_q == 2'd1) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 2'd1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (match_c) begin
                        if (prev_q == LAST) begin
                            wrap_pulse_d = 1'b1;
                            wrap_count_d = wrap_count + WRAP_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count != '1) begin
                            err_count_d = err_count + ERR_W'(1);
                        end
                        state_d = LOST;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment; pulses are unaffected.
        if (clr) begin
            err_count_d  = '0;
            wrap_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    assign state = state_q;

endmodule

// File: tb/tb_counter_mod12_monitor.sv
// Directed bench for counter_mod12_monitor: expectations are queued when a
// step is driven and popped and compared one edge later.
module tb_counter_mod12_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] count_in;
    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] st;
        logic       lk;
        logic       ep;
        logic       wp;
        logic [7:0] ec;
        logic [7:0] wc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    counter_mod12_monitor #(
        .N(12), .WIDTH(4), .ERR_W(8), .WRAP_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .count_in   (count_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] st, input logic ep, input logic wp,
                            input logic [7:0] ec, input logic [7:0] wc);
        exp_t e;
        e.st = st;
        e.lk = (st == 2'd2);
        e.ep = ep;
        e.wp = wp;
        e.ec = ec;
        e.wc = wc;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check("state",      8'(state),      8'(e.st));
            check("locked",     8'(locked),     8'(e.lk));
            check("err_pulse",  8'(err_pulse),  8'(e.ep));
            check("wrap_pulse", 8'(wrap_pulse), 8'(e.wp));
            check("err_count",  err_count,      e.ec);
            check("wrap_count", wrap_count,     e.wc);
        end
    endtask

    // Drive one sample, then check the registered decision after the edge.
    task automatic step(input logic e_in, input logic c_in, input logic [3:0] cin,
                        input logic [1:0] st, input logic ep, input logic wp,
                        input logic [7:0] ec, input logic [7:0] wc);
        @(negedge clk);
        en       = e_in;
        clr      = c_in;
        count_in = cin;
        push_exp(st, ep, wp, ec, wc);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        count_in = 4'd0;

        // Reset held for two edges, then released with en low.
        repeat (2) @(posedge clk);
        #1;
        push_exp(2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        compare_head();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Lock acquisition: capture, match, match.
        step(1'b1, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 4'd1, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 4'd2, 2'd2, 1'b0, 1'b0, 8'd0, 8'd0);

        // Run up to the wrap.
        for (int v = 3; v <= 11; v++)
            step(1'b1, 1'b0, 4'(v), 2'd2, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 4'd0, 2'd2, 1'b0, 1'b1, 8'd0, 8'd1);
        step(1'b1, 1'b0, 4'd1, 2'd2, 1'b0, 1'b0, 8'd0, 8'd1);

        // Error and recovery from 4: 5 ok, 7 breaks, 8 and 9 relock.
        for (int v = 2; v <= 5; v++)
            step(1'b1, 1'b0, 4'(v), 2'd2, 1'b0, 1'b0, 8'd0, 8'd1);
        step(1'b1, 1'b0, 4'd7, 2'd3, 1'b1, 1'b0, 8'd1, 8'd1);
        step(1'b1, 1'b0, 4'd8, 2'd3, 1'b0, 1'b0, 8'd1, 8'd1);
        step(1'b1, 1'b0, 4'd9, 2'd2, 1'b0, 1'b0, 8'd1, 8'd1);

        // Out-of-range sample while locked at 3, then relock on 0,1,2.
        step(1'b1, 1'b0, 4'd10, 2'd2, 1'b0, 1'b0, 8'd1, 8'd1);
        step(1'b1, 1'b0, 4'd11, 2'd2, 1'b0, 1'b0, 8'd1, 8'd1);
        step(1'b1, 1'b0, 4'd0,  2'd2, 1'b0, 1'b1, 8'd1, 8'd2);
        for (int v = 1; v <= 3; v++)
            step(1'b1, 1'b0, 4'(v), 2'd2, 1'b0, 1'b0, 8'd1, 8'd2);
        step(1'b1, 1'b0, 4'd13, 2'd3, 1'b1, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd0,  2'd3, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd1,  2'd3, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd2,  2'd2, 1'b0, 1'b0, 8'd2, 8'd2);

        // Disable returns to IDLE with tallies held; IDLE ignores out-of-range.
        step(1'b0, 1'b0, 4'd5,  2'd0, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd14, 2'd0, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd0,  2'd1, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd1,  2'd1, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b0, 4'd2,  2'd2, 1'b0, 1'b0, 8'd2, 8'd2);

        // Clear coinciding with a wrap: tallies zero, pulse still fires.
        for (int v = 3; v <= 11; v++)
            step(1'b1, 1'b0, 4'(v), 2'd2, 1'b0, 1'b0, 8'd2, 8'd2);
        step(1'b1, 1'b1, 4'd0, 2'd2, 1'b0, 1'b1, 8'd0, 8'd0);
        step(1'b1, 1'b0, 4'd1, 2'd2, 1'b0, 1'b0, 8'd0, 8'd0);

        // Saturation: each 5,6,7 triple is one error plus a relock.
        for (int i = 1; i <= 257; i++) begin
            step(1'b1, 1'b0, 4'd5, 2'd3, 1'b1, 1'b0, 8'((i > 255) ? 255 : i), 8'd0);
            step(1'b1, 1'b0, 4'd6, 2'd3, 1'b0, 1'b0, 8'd255 & 8'((i > 255) ? 255 : i), 8'd0);
            step(1'b1, 1'b0, 4'd7, 2'd2, 1'b0, 1'b0, 8'((i > 255) ? 255 : i), 8'd0);
        end

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        push_exp(2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        compare_head();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        step(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);

        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
